// File: rtl/qeciphy_pkg.sv
// Shared constants and the channel map of the PHY status bank.
package qeciphy_pkg;

  localparam int unsigned QECIPHY_SYNC_STAGES_MIN   = 2;
  localparam int unsigned QECIPHY_FILTER_CYCLES_MIN = 1;
  localparam int unsigned QECIPHY_STATUS_NUM_CH     = 8;

  // Bit positions of the status bank as wired into qeciphy_status_sync.
  typedef enum logic [2:0] {
    GT_RX_RST_DONE       = 3'd0,
    GT_TX_RST_DONE       = 3'd1,
    GT_POWER_GOOD        = 3'd2,
    RX_FAULT_FATAL       = 3'd3,
    RX_RDY               = 3'd4,
    REMOTE_RX_RDY        = 3'd5,
    RX_FIFO_OVERFLOW     = 3'd6,
    RX_DATAPATH_RST_DONE = 3'd7
  } qeciphy_status_ch_e;

  // The stability counter must hold 0..FILTER_CYCLES.
  function automatic int unsigned qeciphy_cnt_width(input int unsigned filter_cycles);
    return (filter_cycles < 1) ? 1 : $clog2(filter_cycles + 1);
  endfunction

endpackage

// File: rtl/qeciphy_status_filter_ch.sv
// One status channel: flop-chain synchroniser, stability filter, edge pulses and
// an optional sticky change flag (present when QECIPHY_STATUS_SYNC_STICKY_EN is defined).
module qeciphy_status_filter_ch
  import qeciphy_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter logic        RESET_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  input  logic sticky_clr,
  output logic status,
  output logic rise,
  output logic fall,
  output logic sticky
);

  localparam int unsigned     CNT_W    = qeciphy_cnt_width(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  // Only the first stage sees a truly asynchronous input.
  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_reg;
  logic sync_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], src};
    end
  end

  assign sync_bit = sync_reg[SYNC_STAGES-1];

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             status_reg, status_next;
  logic             rise_reg, rise_next;
  logic             fall_reg, fall_next;

  // Any cycle where the synchronised level agrees with status restarts the count.
  always_comb begin
    cnt_next    = '0;
    status_next = status_reg;
    rise_next   = 1'b0;
    fall_next   = 1'b0;
    if (sync_bit != status_reg) begin
      if (cnt_reg == CNT_LAST) begin
        status_next = sync_bit;
        rise_next   = sync_bit;
        fall_next   = ~sync_bit;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      status_reg <= RESET_VAL;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      status_reg <= status_next;
      rise_reg   <= rise_next;
      fall_reg   <= fall_next;
    end
  end

  assign status = status_reg;
  assign rise   = rise_reg;
  assign fall   = fall_reg;

`ifdef QECIPHY_STATUS_SYNC_STICKY_EN
  logic sticky_reg, sticky_next;

  // A new edge on the same cycle as a clear keeps the flag set.
  always_comb begin
    sticky_next = sticky_reg;
    if (sticky_clr) begin
      sticky_next = 1'b0;
    end
    if (rise_next || fall_next) begin
      sticky_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_reg <= 1'b0;
    end else begin
      sticky_reg <= sticky_next;
    end
  end

  assign sticky = sticky_reg;
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky            = 1'b0;
`endif

endmodule

// File: rtl/qeciphy_status_sync.sv
// Multi-channel status synchroniser with per-channel stability filter and edge pulses.
// Sticky change flags exist only when QECIPHY_STATUS_SYNC_STICKY_EN is defined.
module qeciphy_status_sync
  import qeciphy_pkg::*;
#(
  parameter int unsigned       NUM_CH        = 8,
  parameter int unsigned       SYNC_STAGES   = 2,
  parameter int unsigned       FILTER_CYCLES = 4,
  parameter logic [NUM_CH-1:0] RESET_VAL     = '0
) (
  input  logic              dst_clk_i,
  input  logic              dst_rst_n_i,
  input  logic [NUM_CH-1:0] src_in_i,
  input  logic [NUM_CH-1:0] sticky_clr_i,
  output logic [NUM_CH-1:0] status_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] fall_o,
  output logic [NUM_CH-1:0] sticky_o
);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("qeciphy_status_sync: NUM_CH must be at least 1");
  end

  if (SYNC_STAGES < QECIPHY_SYNC_STAGES_MIN) begin : g_bad_sync_stages
    $error("qeciphy_status_sync: SYNC_STAGES must be at least %0d", QECIPHY_SYNC_STAGES_MIN);
  end

  if (FILTER_CYCLES < QECIPHY_FILTER_CYCLES_MIN) begin : g_bad_filter_cycles
    $error("qeciphy_status_sync: FILTER_CYCLES must be at least %0d", QECIPHY_FILTER_CYCLES_MIN);
  end

  // Channels are independent; no coherency between bits is implied.
  genvar gi;
  for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
    qeciphy_status_filter_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .RESET_VAL    (RESET_VAL[gi])
    ) u_ch (
      .clk       (dst_clk_i),
      .rst_n     (dst_rst_n_i),
      .src       (src_in_i[gi]),
      .sticky_clr(sticky_clr_i[gi]),
      .status    (status_o[gi]),
      .rise      (rise_o[gi]),
      .fall      (fall_o[gi]),
      .sticky    (sticky_o[gi])
    );
  end

endmodule

// File: tb/tb_qeciphy_status_sync.sv
// Self-checking bench for qeciphy_status_sync: default build (2 stages, filter 4) and a
// 3-stage / filter-1 instance, checked against a sliding-window reference model.
module tb_qeciphy_status_sync;
  import qeciphy_pkg::*;

`ifdef QECIPHY_STATUS_SYNC_STICKY_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif
  localparam logic [7:0] STK_MASK = {8{STICKY_EN}};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] src = '0;
  logic [7:0] clr = '0;
  logic [7:0] status_a, rise_a, fall_a, sticky_a;
  logic [7:0] status_b, rise_b, fall_b, sticky_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  qeciphy_status_sync #(.NUM_CH(8), .SYNC_STAGES(2), .FILTER_CYCLES(4), .RESET_VAL(8'h00)) dut_a (
    .dst_clk_i(clk), .dst_rst_n_i(rst_n), .src_in_i(src), .sticky_clr_i(clr),
    .status_o(status_a), .rise_o(rise_a), .fall_o(fall_a), .sticky_o(sticky_a)
  );

  qeciphy_status_sync #(.NUM_CH(8), .SYNC_STAGES(3), .FILTER_CYCLES(1), .RESET_VAL(8'h00)) dut_b (
    .dst_clk_i(clk), .dst_rst_n_i(rst_n), .src_in_i(src), .sticky_clr_i(clr),
    .status_o(status_b), .rise_o(rise_b), .fall_o(fall_b), .sticky_o(sticky_b)
  );

  // Reference model: a change is accepted once the last F sampled synchronised
  // values all disagree with the current status; the synchroniser is a plain delay.
  int         m_s [2] = '{2, 3};
  int         m_f [2] = '{4, 1};
  logic [7:0] m_pipe [2][4];
  logic [7:0] m_win  [2][4];
  logic [7:0] m_status [2];
  logic [7:0] m_rise [2];
  logic [7:0] m_fall [2];
  logic [7:0] m_sticky [2];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) begin
        m_pipe[k][j] = '0;
        m_win[k][j]  = '0;
      end
      m_status[k] = '0;
      m_rise[k]   = '0;
      m_fall[k]   = '0;
      m_sticky[k] = '0;
    end
  endtask

  task automatic model_edge(input logic [7:0] s, input logic [7:0] c);
    logic [7:0] sync, acc;
    for (int k = 0; k < 2; k++) begin
      sync = m_pipe[k][m_s[k]-1];
      for (int j = 3; j > 0; j--) begin
        m_pipe[k][j] = m_pipe[k][j-1];
        m_win[k][j]  = m_win[k][j-1];
      end
      m_pipe[k][0] = s;
      m_win[k][0]  = sync;
      acc = 8'hFF;
      for (int j = 0; j < m_f[k]; j++) acc &= (m_win[k][j] ^ m_status[k]);
      m_rise[k]   = acc & ~m_status[k];
      m_fall[k]   = acc & m_status[k];
      m_status[k] = m_status[k] ^ acc;
      m_sticky[k] = ((m_sticky[k] & ~c) | acc) & STK_MASK;
    end
  endtask

  task automatic compare_model();
    check("a_status", status_a, m_status[0]);
    check("a_rise",   rise_a,   m_rise[0]);
    check("a_fall",   fall_a,   m_fall[0]);
    check("a_sticky", sticky_a, m_sticky[0]);
    check("b_status", status_b, m_status[1]);
    check("b_rise",   rise_b,   m_rise[1]);
    check("b_fall",   fall_b,   m_fall[1]);
    check("b_sticky", sticky_b, m_sticky[1]);
  endtask

  // Inputs change 1 time unit after each rising edge, outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge(src, clr);
    #1;
    compare_model();
  endtask

  task automatic do_reset(input logic [7:0] s);
    rst_n = 1'b0;
    model_reset();
    src = s;
    clr = '0;
    #1;
    compare_model();
    repeat (2) tick();
    check("rst_status", status_a, 8'h00);
    check("rst_rise", rise_a, 8'h00);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] src, clr, status, rise, fall, sticky;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int   rise_cnt, rise_at, fall_cnt, fall_at, lat;
    logic [7:0] seen;

    // Reset release with all sources high, then a drop; sticky column assumes flags enabled.
    for (int i = 0; i < 5; i++) vecs[i] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[5]  = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF};
    vecs[6]  = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF};
    vecs[7]  = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF};
    vecs[8]  = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
    vecs[9]  = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};
    vecs[10] = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};
    vecs[11] = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};
    vecs[12] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
    vecs[13] = '{8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 8'hF0};

    model_reset();
    do_reset(8'hFF);
    for (int i = 0; i < 14; i++) begin
      src = vecs[i].src;
      clr = vecs[i].clr;
      tick();
      check("vec_status", status_a, vecs[i].status);
      check("vec_rise",   rise_a,   vecs[i].rise);
      check("vec_fall",   fall_a,   vecs[i].fall);
      check("vec_sticky", sticky_a, vecs[i].sticky & STK_MASK);
      $display("vec %0d: src=%h clr=%h status=%h rise=%h fall=%h sticky=%h",
               i + 1, src, clr, status_a, rise_a, fall_a, sticky_a);
    end
    clr = '0;

    // Three-cycle glitch on RX_FAULT_FATAL must be filtered out.
    do_reset(8'h00);
    seen = '0;
    src = 8'h08;
    repeat (3) begin
      tick();
      seen |= (status_a | rise_a | sticky_a) & 8'h08;
    end
    src = 8'h00;
    repeat (10) begin
      tick();
      seen |= (status_a | rise_a | sticky_a) & 8'h08;
    end
    check("glitch_ch3", seen, 8'h00);
    $display("seq glitch: ch%0d activity=%h", int'(RX_FAULT_FATAL), seen);

    // Ten-cycle pulse on GT_RX_RST_DONE: one rise at edge 6, one fall 6 edges after the drop.
    do_reset(8'h00);
    rise_cnt = 0; rise_at = 0; fall_cnt = 0; fall_at = 0;
    src = 8'h01;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (rise_a[GT_RX_RST_DONE]) begin rise_cnt++; rise_at = i; end
    end
    src = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (fall_a[GT_RX_RST_DONE]) begin fall_cnt++; fall_at = i; end
    end
    check("pulse_rise_cnt", 8'(rise_cnt), 8'd1);
    check("pulse_rise_at", 8'(rise_at), 8'd6);
    check("pulse_fall_cnt", 8'(fall_cnt), 8'd1);
    check("pulse_fall_at", 8'(fall_at), 8'd6);
    check("pulse_sticky", sticky_a & 8'h01, 8'h01 & STK_MASK);
    $display("seq pulse: rises=%0d@%0d falls=%0d@%0d sticky=%h",
             rise_cnt, rise_at, fall_cnt, fall_at, sticky_a);

    // Clear coinciding with a new rise keeps sticky set; a clear alone then drops it.
    src = 8'h01;
    repeat (5) tick();
    clr = 8'h01;
    tick();
    check("race_rise", rise_a & 8'h01, 8'h01);
    check("race_sticky_set", sticky_a & 8'h01, 8'h01 & STK_MASK);
    tick();
    check("race_sticky_clr", sticky_a & 8'h01, 8'h00);
    clr = 8'h00;
    $display("seq sticky race: sticky=%h", sticky_a);

    // Reset asserted two cycles into a count; outputs drop immediately, count restarts.
    src = 8'h03;
    repeat (4) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_status", status_a, 8'h00);
    check("midrst_sticky", sticky_a, 8'h00);
    compare_model();
    repeat (2) tick();
    rst_n = 1'b1;
    rise_at = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (rise_a[GT_TX_RST_DONE] && rise_at == 0) rise_at = i;
      if (i == 6) check("midrst_rise6", rise_a, 8'h03);
    end
    check("midrst_rise_at", 8'(rise_at), 8'd6);
    $display("seq mid-count reset: rise after release at edge %0d", rise_at);

    // Three stages with a one-cycle filter: latency of four edges.
    do_reset(8'h00);
    src = 8'hFF;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (lat == 0 && status_b != 8'h00) lat = i;
    end
    check("cfg_b_latency", 8'(lat), 8'd4);
    $display("seq config b: latency=%0d edges", lat);

    // Randomised stimulus against the model, with occasional resets.
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 3) == 0) src = src ^ 8'($urandom() & $urandom());
        clr = ($urandom_range(0, 7) == 0) ? 8'($urandom()) : 8'h00;
        if ($urandom_range(0, 99) == 0) begin
          rst_n = 1'b0;
          model_reset();
          #1;
          compare_model();
          repeat ($urandom_range(1, 3)) tick();
          rst_n = 1'b1;
        end
        tick();
      end
      $display("random block %0d: checks=%0d errors=%0d", blk, n_checks, n_errors);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
